// File: rtl/neopixel_frame_sequencer_if.sv
// Load/send handshake between the frame sequencer and the strand controller.
// The sequencer (master) drives the colour-load and send strobes.
// The controller (slave) returns the ready_to_load / ready_to_send acknowledges.
interface neopixel_frame_sequencer_if;
  logic       load_color;
  logic [1:0] color_index;
  logic [2:0] pixel_index;
  logic [7:0] color_level;
  logic       send_it;
  logic       ready_to_load;
  logic       ready_to_send;

  modport master (
    output load_color, color_index, pixel_index, color_level, send_it,
    input  ready_to_load, ready_to_send
  );

  modport slave (
    input  load_color, color_index, pixel_index, color_level, send_it,
    output ready_to_load, ready_to_send
  );
endinterface

// File: rtl/neopixel_frame_sequencer.sv
// Frame source for the NeoPixel strand: loads 3*NUM_PIXELS levels, sends, waits, gaps.
// Latency: load/send strobes are combinational from ready_* in the LOAD/SEND states.
// Backpressure: ready_to_load low freezes pixel/channel; ready_to_send gates send and completion.
module neopixel_frame_sequencer #(
  parameter int NUM_PIXELS = 5,
  parameter int FRAME_GAP  = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] base_r,
  input  logic [7:0] base_g,
  input  logic [7:0] base_b,
  neopixel_frame_sequencer_if.master strand,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] frame_count
);

  localparam logic [2:0]  LAST_PIX = 3'(NUM_PIXELS - 1);
  localparam logic [19:0] GAP_LAST = 20'(FRAME_GAP - 1);

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_CHASE = 2'd1;
  localparam logic [1:0] MODE_FADE  = 2'd2;

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  pix;
  logic [1:0]  ch;
  logic [2:0]  chase_pos;
  logic [19:0] gap_cnt;
  logic [1:0]  lat_mode;
  logic [7:0]  lat_r, lat_g, lat_b, lat_fc;

  logic        start_frame, load_stb, send_stb, done_stb;
  logic        last_chan, gap_end;
  logic [7:0]  base_sel, level;
  logic [15:0] fade_prod;

  assign last_chan = (pix == LAST_PIX) && (ch == 2'd2);
  assign gap_end   = (gap_cnt == GAP_LAST);

  // Next-state and handshake strobes; strobes only exist in their own states.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    load_stb    = 1'b0;
    send_stb    = 1'b0;
    done_stb    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && strand.ready_to_load) begin
          state_nxt   = LOAD;
          start_frame = 1'b1;
        end
      end
      LOAD: begin
        load_stb = strand.ready_to_load;
        if (load_stb && last_chan) state_nxt = SEND;
      end
      SEND: begin
        send_stb = strand.ready_to_send;
        if (send_stb) state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!strand.ready_to_send) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (strand.ready_to_send) begin
          done_stb  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_end) begin
          if (enable && strand.ready_to_load) begin
            state_nxt   = LOAD;
            start_frame = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pattern level for the current pixel/channel, from values latched at frame start.
  always_comb begin
    case (ch)
      2'd1:    base_sel = lat_b;
      2'd2:    base_sel = lat_g;
      default: base_sel = lat_r;
    endcase
    fade_prod = {8'd0, base_sel} * {8'd0, lat_fc};
    case (lat_mode)
      MODE_SOLID: level = base_sel;
      MODE_CHASE: level = (pix == chase_pos) ? base_sel : 8'd0;
      MODE_FADE:  level = fade_prod[15:8];
      default:    level = 8'd0;
    endcase
  end

  assign strand.load_color  = load_stb;
  assign strand.send_it     = send_stb;
  assign strand.pixel_index = (state == LOAD) ? pix : 3'd0;
  assign strand.color_index = (state == LOAD) ? ch : 2'd0;
  assign strand.color_level = (state == LOAD) ? level : 8'd0;
  assign frame_done         = done_stb;
  assign busy               = (state != IDLE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pixel/channel walk R->B->G per pixel; restarts at each new frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix <= 3'd0;
      ch  <= 2'd0;
    end else if (start_frame) begin
      pix <= 3'd0;
      ch  <= 2'd0;
    end else if (load_stb) begin
      if (ch == 2'd2) begin
        ch  <= 2'd0;
        pix <= last_chan ? 3'd0 : pix + 3'd1;
      end else begin
        ch <= ch + 2'd1;
      end
    end
  end

  // Snapshot pattern inputs so mid-frame changes cannot tear a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_mode <= 2'd0;
      lat_r    <= 8'd0;
      lat_g    <= 8'd0;
      lat_b    <= 8'd0;
      lat_fc   <= 8'd0;
    end else if (start_frame) begin
      lat_mode <= mode;
      lat_r    <= base_r;
      lat_g    <= base_g;
      lat_b    <= base_b;
      lat_fc   <= frame_count;
    end
  end

  // Frame completion bookkeeping: frame counter and chase position advance together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count <= 8'd0;
      chase_pos   <= 3'd0;
    end else if (done_stb) begin
      frame_count <= frame_count + 8'd1;
      chase_pos   <= (chase_pos == LAST_PIX) ? 3'd0 : chase_pos + 3'd1;
    end
  end

  // Inter-frame gap timer, cleared whenever the sequencer is not in GAP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     gap_cnt <= 20'd0;
    else if (state == GAP && !gap_end) gap_cnt <= gap_cnt + 20'd1;
    else                           gap_cnt <= 20'd0;
  end

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Directed bench for neopixel_frame_sequencer with a simple strand controller model.
// Runs with a 2-cycle frame gap so long frame-count runs stay short.
// Expected levels and timings come from hand-derived tables and small formulas.
module tb_neopixel_frame_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] base_r, base_g, base_b;
  logic       frame_done, busy;
  logic [7:0] frame_count;

  neopixel_frame_sequencer_if strand ();

  neopixel_frame_sequencer #(.NUM_PIXELS(5), .FRAME_GAP(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .base_r     (base_r),
    .base_g     (base_g),
    .base_b     (base_b),
    .strand     (strand),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller model: after accepting send_it it goes busy briefly, then reports completion.
  initial begin
    strand.ready_to_send = 1'b1;
    forever begin
      @(negedge clock);
      if (strand.send_it) begin
        @(posedge clock); #1 strand.ready_to_send = 1'b0;
        repeat (4) @(posedge clock);
        #1 strand.ready_to_send = 1'b1;
      end
    end
  end

  // Monitor: records strobes, sends, completions and gap lengths on the falling edge.
  int strb_pix[$], strb_ch[$], strb_lvl[$], strb_cyc[$];
  int send_cyc[$], gap_q[$], fcd_q[$];
  int cyc = 0, done_cyc = 0, n_done = 0, n_ovl = 0, n_dbl = 0;
  logic pend = 1'b0, prev_send = 1'b0;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    prev_send <= strand.send_it;
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (strand.load_color) begin
        strb_pix.push_back(int'(strand.pixel_index));
        strb_ch.push_back(int'(strand.color_index));
        strb_lvl.push_back(int'(strand.color_level));
        strb_cyc.push_back(cyc);
        if (pend) begin
          gap_q.push_back(cyc - done_cyc);
          pend <= 1'b0;
        end
      end
      if (frame_done) begin
        n_done <= n_done + 1;
        fcd_q.push_back(int'(frame_count));
        done_cyc <= cyc;
        pend <= 1'b1;
      end
      if (strand.send_it) begin
        send_cyc.push_back(cyc);
        if (prev_send) n_dbl <= n_dbl + 1;
      end
      if (strand.load_color && strand.send_it) n_ovl <= n_ovl + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int chan_val(input int r, input int g, input int b, input int c);
    return (c == 0) ? r : (c == 1) ? b : g;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(posedge clock); #1;
      k++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_dones(input string tag, input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(posedge clock); #1;
      k++;
    end
    check({tag, "_dones"}, n_done, target);
  endtask

  task automatic start_one_frame();
    enable = 1'b1;
    @(posedge clock); #1 enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  int sb, sd, dd, gb, fb, k, idx, f, ev;

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0;
    base_r = 8'd0; base_g = 8'd0; base_b = 8'd0;
    strand.ready_to_load = 1'b1;
    repeat (3) @(posedge clock); #1;

    // Reset state: everything quiet.
    check("rst_busy", busy, 0);
    check("rst_load", strand.load_color, 0);
    check("rst_send", strand.send_it, 0);
    check("rst_done", frame_done, 0);
    check("rst_fc", frame_count, 0);
    check("rst_pix", strand.pixel_index, 0);
    check("rst_lvl", strand.color_level, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;
    check("idle_no_enable", busy, 0);

    // Test 1: SOLID, controller always ready -> 15 back-to-back strobes then one send.
    mode = 2'd0; base_r = 8'd10; base_g = 8'd20; base_b = 8'd30;
    sb = strb_pix.size(); sd = send_cyc.size(); dd = n_done;
    start_one_frame();
    wait_idle("t1", 200);
    check("t1_nstrobe", strb_pix.size() - sb, 15);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 3; c++) begin
        idx = sb + 3 * p + c;
        check($sformatf("t1_pix_%0d_%0d", p, c), strb_pix[idx], p);
        check($sformatf("t1_ch_%0d_%0d", p, c), strb_ch[idx], c);
        check($sformatf("t1_lvl_%0d_%0d", p, c), strb_lvl[idx], chan_val(10, 20, 30, c));
        check($sformatf("t1_cyc_%0d_%0d", p, c), strb_cyc[idx] - strb_cyc[sb], 3 * p + c);
      end
    end
    check("t1_nsend", send_cyc.size() - sd, 1);
    check("t1_send_cyc", send_cyc[sd] - strb_cyc[sb + 14], 1);
    check("t1_ndone", n_done - dd, 1);
    check("t1_fc", frame_count, 1);

    // Test 2: ready_to_load low for 3 cycles at pixel 2 blue.
    sb = strb_pix.size();
    start_one_frame();
    k = 0;
    while (!(strand.load_color && strand.pixel_index == 3'd2 && strand.color_index == 2'd0) && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    @(posedge clock); #1 strand.ready_to_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("t2_stall_load_%0d", i), strand.load_color, 0);
      check($sformatf("t2_stall_pix_%0d", i), strand.pixel_index, 2);
      check($sformatf("t2_stall_ch_%0d", i), strand.color_index, 1);
    end
    @(posedge clock); #1 strand.ready_to_load = 1'b1;
    wait_idle("t2", 200);
    check("t2_nstrobe", strb_pix.size() - sb, 15);
    check("t2_resume_pix", strb_pix[sb + 7], 2);
    check("t2_resume_ch", strb_ch[sb + 7], 1);
    check("t2_resume_lvl", strb_lvl[sb + 7], 30);
    check("t2_resume_gap", strb_cyc[sb + 7] - strb_cyc[sb + 6], 4);
    check("t2_span", strb_cyc[sb + 14] - strb_cyc[sb], 17);
    check("t2_fc", frame_count, 2);

    // Test 3: CHASE red, 6 continuous frames -> lit pixel 0,1,2,3,4,0.
    do_reset();
    check("t3_fc_cleared", frame_count, 0);
    mode = 2'd1; base_r = 8'hFF; base_g = 8'd0; base_b = 8'd0;
    sb = strb_pix.size(); dd = n_done; gb = gap_q.size(); fb = fcd_q.size();
    enable = 1'b1;
    wait_dones("t3", dd + 6, 1000);
    enable = 1'b0;
    wait_idle("t3", 200);
    check("t3_nstrobe", strb_pix.size() - sb, 90);
    for (int fr = 0; fr < 6; fr++) begin
      for (int p = 0; p < 5; p++) begin
        for (int c = 0; c < 3; c++) begin
          idx = sb + 15 * fr + 3 * p + c;
          ev = (c == 0 && p == fr % 5) ? 255 : 0;
          check($sformatf("t3_f%0d_p%0d_c%0d", fr, p, c), strb_lvl[idx], ev);
        end
      end
      check($sformatf("t3_fc_at_done_%0d", fr), fcd_q[fb + fr], fr);
    end
    for (int g = 0; g < 5; g++) check($sformatf("t3_gap_%0d", g), gap_q[gb + g], 3);
    check("t3_fc", frame_count, 6);

    // Tests 4/6: FADE green over 257 frames -> counter wrap, fade law, 2-cycle gaps.
    do_reset();
    mode = 2'd2; base_r = 8'd0; base_g = 8'hFF; base_b = 8'd0;
    sb = strb_pix.size(); dd = n_done; gb = gap_q.size(); fb = fcd_q.size();
    enable = 1'b1;
    wait_dones("t6", dd + 257, 12000);
    enable = 1'b0;
    wait_idle("t6", 200);
    check("t6_nstrobe", strb_pix.size() - sb, 257 * 15);
    for (int fr = 0; fr < 257; fr++) begin
      f = fr % 256;
      for (int p = 0; p < 5; p++) begin
        idx = sb + 15 * fr + 3 * p;
        check($sformatf("t6_f%0d_p%0d_r", fr, p), strb_lvl[idx], 0);
        check($sformatf("t6_f%0d_p%0d_b", fr, p), strb_lvl[idx + 1], 0);
        check($sformatf("t6_f%0d_p%0d_g", fr, p), strb_lvl[idx + 2], (255 * f) >> 8);
      end
      check($sformatf("t6_fc_at_done_%0d", fr), fcd_q[fb + fr], f);
      if (fr < 256) check($sformatf("t6_gap_%0d", fr), gap_q[gb + fr], 3);
    end
    check("t4_fade_0x80_g", strb_lvl[sb + 15 * 128 + 2], 8'h7F);
    check("t4_fade_0x80_r", strb_lvl[sb + 15 * 128], 0);
    check("t6_wrap_255", fcd_q[fb + 255], 255);
    check("t6_wrap_0", fcd_q[fb + 256], 0);
    check("t6_fc_final", frame_count, 1);

    // Test 5a: enable dropped during pixel 1 -> frame still completes.
    mode = 2'd0; base_r = 8'd1; base_g = 8'd2; base_b = 8'd3;
    sb = strb_pix.size(); sd = send_cyc.size(); dd = n_done;
    enable = 1'b1;
    k = 0;
    while (!(busy && strand.pixel_index == 3'd1) && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    enable = 1'b0;
    wait_idle("t5a", 200);
    check("t5a_nstrobe", strb_pix.size() - sb, 15);
    check("t5a_nsend", send_cyc.size() - sd, 1);
    check("t5a_ndone", n_done - dd, 1);
    check("t5a_fc", frame_count, 2);

    // Test 5b: reset while waiting for transfer completion.
    sd = send_cyc.size(); dd = n_done;
    start_one_frame();
    k = 0;
    while (send_cyc.size() == sd && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    @(posedge clock); #2;
    check("t5b_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("t5b_busy", busy, 0);
    check("t5b_load", strand.load_color, 0);
    check("t5b_send", strand.send_it, 0);
    check("t5b_done", frame_done, 0);
    check("t5b_fc", frame_count, 0);
    check("t5b_lvl", strand.color_level, 0);
    repeat (6) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("t5b_stay_idle", busy, 0);
    check("t5b_no_done", n_done - dd, 0);

    check("never_load_and_send", n_ovl, 0);
    check("send_single_cycle", n_dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
